// File: rtl/config_loader_if.sv
// Byte-stream input handshake and configuration-memory write port of the config loader.
// The master modport is the host link side; the slave modport is the loader.
interface config_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] config_data;
    logic [7:0]  config_addr;
    logic        config_wren;
    logic        busy;
    logic        pkt_ok;
    logic        pkt_err;
    logic [1:0]  err_code;

    modport master (
        output in_data, in_valid,
        input  in_ready, config_data, config_addr, config_wren,
        input  busy, pkt_ok, pkt_err, err_code
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, config_data, config_addr, config_wren,
        output busy, pkt_ok, pkt_err, err_code
    );
endinterface

// File: rtl/config_loader.sv
// Parses framed write packets (SYNC, ADDR, COUNT, COUNT*4 data bytes, CSUM) from a byte
// stream and issues one 32-bit configuration write per word with an auto-incrementing address.
module config_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic           clk,
    input  logic           reset,
    config_loader_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // The idle counter reads 0 in the first cycle after a consumed byte, so the abort
    // decision is taken when it holds TIMEOUT_CYCLES-2; the error pulse then lands
    // exactly TIMEOUT_CYCLES cycles after the last consumed byte.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_CSUM
    } state_t;

    state_t        r_state,  w_state_next;
    logic          r_in_ready;
    logic [7:0]    r_ptr,    w_ptr_next;
    logic [7:0]    r_cnt,    w_cnt_next;
    logic [7:0]    r_sum,    w_sum_next;
    logic [1:0]    r_idx,    w_idx_next;
    logic [23:0]   r_word,   w_word_next;
    logic [TW-1:0] r_tmo,    w_tmo_next;
    logic [31:0]   r_data,   w_data_next;
    logic [7:0]    r_addr,   w_addr_next;
    logic          r_wren,   w_wren_next;
    logic          r_ok,     w_ok_next;
    logic          r_err,    w_err_next;
    logic [1:0]    r_code,   w_code_next;

    logic          w_accept;
    logic          w_tmo_fire;
    logic [7:0]    w_sum_add;

    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_tmo_fire = (r_state != S_IDLE) && (r_tmo == TMO_LAST);
    assign w_sum_add  = r_sum + bus.in_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_idx      <= '0;
            r_word     <= '0;
            r_tmo      <= '0;
            r_data     <= '0;
            r_addr     <= '0;
            r_wren     <= 1'b0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_code     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= 1'b1;
            r_ptr      <= w_ptr_next;
            r_cnt      <= w_cnt_next;
            r_sum      <= w_sum_next;
            r_idx      <= w_idx_next;
            r_word     <= w_word_next;
            r_tmo      <= w_tmo_next;
            r_data     <= w_data_next;
            r_addr     <= w_addr_next;
            r_wren     <= w_wren_next;
            r_ok       <= w_ok_next;
            r_err      <= w_err_next;
            r_code     <= w_code_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
        w_sum_next   = r_sum;
        w_idx_next   = r_idx;
        w_word_next  = r_word;
        w_tmo_next   = (r_state == S_IDLE || w_accept) ? '0 : r_tmo + TW'(1);
        w_data_next  = r_data;
        w_addr_next  = r_addr;
        w_wren_next  = 1'b0;
        w_ok_next    = 1'b0;
        w_err_next   = 1'b0;
        w_code_next  = r_code;

        // Timeout has priority: a byte offered in the abort cycle is dropped.
        if (w_tmo_fire) begin
            w_state_next = S_IDLE;
            w_err_next   = 1'b1;
            w_code_next  = 2'd2;
            w_idx_next   = '0;
            w_tmo_next   = '0;
        end else if (w_accept) begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_data == SYNC_BYTE) begin
                        w_state_next = S_ADDR;
                    end
                end
                S_ADDR: begin
                    w_ptr_next   = bus.in_data;
                    w_sum_next   = bus.in_data;
                    w_state_next = S_COUNT;
                end
                S_COUNT: begin
                    w_cnt_next   = bus.in_data;
                    w_sum_next   = w_sum_add;
                    w_idx_next   = '0;
                    w_state_next = (bus.in_data != 8'd0) ? S_DATA : S_CSUM;
                end
                S_DATA: begin
                    w_sum_next  = w_sum_add;
                    w_word_next = {r_word[15:0], bus.in_data};
                    w_idx_next  = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_data_next = {r_word, bus.in_data};
                        w_addr_next = r_ptr;
                        w_wren_next = 1'b1;
                        w_ptr_next  = r_ptr + 8'd1;
                        w_cnt_next  = r_cnt - 8'd1;
                        if (r_cnt == 8'd1) begin
                            w_state_next = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_sum_add == 8'd0) begin
                        w_ok_next   = 1'b1;
                        w_code_next = 2'd0;
                    end else begin
                        w_err_next  = 1'b1;
                        w_code_next = 2'd1;
                    end
                    w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.config_data = r_data;
    assign bus.config_addr = r_addr;
    assign bus.config_wren = r_wren;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.pkt_ok      = r_ok;
    assign bus.pkt_err     = r_err;
    assign bus.err_code    = r_code;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: directed packets from the test plan plus randomized packets,
// checked against a packet-level model of expected writes and completion events.
module tb_config_loader;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    config_loader_if bus ();

    config_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int t; logic [7:0] a; logic [31:0] d; } wr_t;
    typedef struct { int t; logic ok; logic [1:0] code; } ev_t;

    int   nchk = 0;
    int   nfail = 0;
    int   ecnt = 0;
    wr_t  obs_wr[$];
    wr_t  exp_wr[$];
    ev_t  obs_ev[$];
    ev_t  exp_ev[$];
    logic [31:0] pw[$];
    logic [1:0]  last_code = 2'd0;

    always @(posedge clk) ecnt++;

    // Collect every write and completion pulse with the cycle it was seen in.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.config_wren) begin
                wr_t w;
                w.t = ecnt; w.a = bus.config_addr; w.d = bus.config_data;
                obs_wr.push_back(w);
            end
            if (bus.pkt_ok || bus.pkt_err) begin
                ev_t e;
                nchk++;
                assert (!(bus.pkt_ok && bus.pkt_err)) else begin
                    nfail++;
                    $error("FAIL ok_err_exclusive: observed ok=%0b err=%0b required not both", bus.pkt_ok, bus.pkt_err);
                end
                e.t = ecnt; e.ok = bus.pkt_ok; e.code = bus.err_code;
                obs_ev.push_back(e);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] b, output int t);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = ecnt;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic push_ev(input int t, input logic ok, input logic [1:0] code);
        ev_t e;
        e.t = t; e.ok = ok; e.code = code;
        exp_ev.push_back(e);
        last_code = code;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk($sformatf("%s.in_ready", tag), 32'(bus.in_ready), 32'd0);
        chk($sformatf("%s.wren", tag), 32'(bus.config_wren), 32'd0);
        chk($sformatf("%s.data", tag), bus.config_data, 32'd0);
        chk($sformatf("%s.addr", tag), 32'(bus.config_addr), 32'd0);
        chk($sformatf("%s.busy", tag), 32'(bus.busy), 32'd0);
        chk($sformatf("%s.ok", tag), 32'(bus.pkt_ok), 32'd0);
        chk($sformatf("%s.err", tag), 32'(bus.pkt_err), 32'd0);
        chk($sformatf("%s.code", tag), 32'(bus.err_code), 32'd0);
    endtask

    task automatic compare(input string tag);
        chk($sformatf("%s.nwr", tag), obs_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            chk($sformatf("%s.wr%0d.addr", tag, i), 32'(obs_wr[i].a), 32'(exp_wr[i].a));
            chk($sformatf("%s.wr%0d.data", tag, i), obs_wr[i].d, exp_wr[i].d);
            chk($sformatf("%s.wr%0d.cycle", tag, i), obs_wr[i].t, exp_wr[i].t);
        end
        chk($sformatf("%s.nev", tag), obs_ev.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
            chk($sformatf("%s.ev%0d.ok", tag, i), 32'(obs_ev[i].ok), 32'(exp_ev[i].ok));
            chk($sformatf("%s.ev%0d.code", tag, i), 32'(obs_ev[i].code), 32'(exp_ev[i].code));
            chk($sformatf("%s.ev%0d.cycle", tag, i), obs_ev[i].t, exp_ev[i].t);
        end
        chk($sformatf("%s.code_hold", tag), 32'(bus.err_code), 32'(last_code));
        chk($sformatf("%s.busy_end", tag), 32'(bus.busy), 32'd0);
        obs_wr.delete(); exp_wr.delete(); obs_ev.delete(); exp_ev.delete();
    endtask

    // Model: build the byte list from pw, send the first 'cut' bytes (all if cut==0),
    // expect one write per fully sent word and one completion event.
    task automatic run_packet(input logic [7:0] addr, input logic [7:0] csum_delta,
                              input int cut, input int maxgap, input string tag);
        logic [7:0] bl[$];
        logic [7:0] s;
        int t, k, nb;
        bl.push_back(8'hA5);
        bl.push_back(addr);
        bl.push_back(8'(pw.size()));
        s = addr + 8'(pw.size());
        foreach (pw[i]) begin
            for (int j = 0; j < 4; j++) begin
                bl.push_back(pw[i][31-8*j -: 8]);
                s = s + pw[i][31-8*j -: 8];
            end
        end
        bl.push_back((8'h00 - s) + csum_delta);
        nb = bl.size();
        k  = (cut > 0 && cut < nb) ? cut : nb;
        t  = 0;
        for (int i = 0; i < k; i++) begin
            if (i > 0 && maxgap > 0) idle($urandom_range(maxgap, 0));
            drive(bl[i], t);
            if (i == 0) chk($sformatf("%s.busy_sync", tag), 32'(bus.busy), 32'd1);
            if (i >= 3 && i < nb - 1 && ((i - 3) % 4) == 3) begin
                wr_t w;
                w.t = t + 1;
                w.a = addr + 8'((i - 3) / 4);
                w.d = pw[(i - 3) / 4];
                exp_wr.push_back(w);
            end
            if (i == nb - 1) push_ev(t + 1, csum_delta == 8'd0, (csum_delta == 8'd0) ? 2'd0 : 2'd1);
        end
        if (k < nb) push_ev(t + 16, 1'b0, 2'd2);
        idle(20);
        compare(tag);
    endtask

    initial begin
        int t;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        idle(3);
        chk_outputs_zero("reset");
        reset = 1'b0;
        idle(1);
        chk("ready_after_reset", 32'(bus.in_ready), 32'd1);

        pw = '{32'hDEADBEEF};
        run_packet(8'h10, 8'h00, 0, 0, "single");
        pw = '{32'hDEADBEEF};
        run_packet(8'h10, 8'hFF, 0, 0, "csum_err");
        pw = '{32'h00000001, 32'h00000002};
        run_packet(8'hFF, 8'h00, 0, 0, "wrap");

        drive(8'h00, t);
        chk("garbage0.busy", 32'(bus.busy), 32'd0);
        drive(8'h3C, t);
        chk("garbage1.busy", 32'(bus.busy), 32'd0);
        pw.delete();
        run_packet(8'h20, 8'h00, 0, 0, "zero_count");

        pw = '{32'hDEADBEEF};
        run_packet(8'h10, 8'h00, 5, 0, "timeout");

        // A sync byte offered in the abort cycle must be dropped.
        drive(8'hA5, t); drive(8'h10, t); drive(8'h01, t); drive(8'hDE, t);
        push_ev(t + 16, 1'b0, 2'd2);
        idle(14);
        drive(8'hA5, t);
        pw.delete();
        run_packet(8'h20, 8'h00, 0, 0, "tmo_collide");

        drive(8'hA5, t); drive(8'h10, t); drive(8'h01, t); drive(8'hDE, t); drive(8'hAD, t);
        reset = 1'b1;
        #1;
        chk_outputs_zero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_reset", 32'(bus.in_ready), 32'd1);
        obs_wr.delete(); obs_ev.delete();
        last_code = 2'd0;
        pw = '{32'hCAFEF00D};
        run_packet(8'h20, 8'h00, 0, 0, "after_reset");

        for (int n = 0; n < 20; n++) begin
            int nw, cut;
            logic [7:0] delta;
            nw = $urandom_range(3, 0);
            pw.delete();
            for (int w = 0; w < nw; w++) pw.push_back($urandom);
            delta = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            cut   = ($urandom_range(5, 0) == 0) ? $urandom_range(3 + 4 * nw, 1) : 0;
            run_packet(8'($urandom), delta, cut, 3, $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
